qam_demapper_multi: RTL and testbench
=====================================

QAM_DEMAPPER_MULTI -- requirements
Module: qam_demapper_multi

Interface
REQ-001 Parameter DATA_W, default 24, SHALL set the width of the signed two's-complement I/Q sample.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the output FIFO depth; it SHALL be a power of two and at least 4.
REQ-003 Parameter FRAME_LEN, default 64, SHALL set the number of symbols per frame; it SHALL be at least 1.
REQ-004 Clk  in  1  is the single clock; all logic SHALL be on the rising edge.
REQ-005 Rst  in  1  is the reset, asynchronous and active-high.
REQ-006 InValid  in  1  SHALL mark an input sample.
REQ-007 InRe  in  DATA_W  SHALL carry the signed I sample.
REQ-008 InIm  in  DATA_W  SHALL carry the signed Q sample.
REQ-009 InReady  out  1  SHALL signal that the block can accept a sample.
REQ-010 Mode  in  2  SHALL select the constellation: 0 = 4-QAM, 1 = 16-QAM, 2 = 64-QAM, 3 = reserved.
REQ-011 ThreshUnit  in  DATA_W  SHALL carry the unsigned decision unit U.
REQ-012 OutValid  out  1  SHALL mark a valid output symbol.
REQ-013 OutData  out  6  SHALL carry the demapped symbol, right-aligned with unused upper bits 0.
REQ-014 OutLast  out  1  SHALL mark the last symbol of a frame.
REQ-015 OutReady  in  1  SHALL signal that downstream accepts the symbol.
REQ-016 ModeErr  out  1  SHALL be a sticky flag set when a frame starts with Mode = 3.

Function
REQ-017 The block SHALL accept an input sample on every rising edge where InValid and InReady are both 1.
REQ-018 The block SHALL transfer an output symbol on every rising edge where OutValid and OutReady are both 1.
REQ-019 Frame FSM, IDLE: the block SHALL latch Mode and ThreshUnit on the first accepted sample, count that sample as symbol 0, and go to ACTIVE (or stay in IDLE when FRAME_LEN = 1).
REQ-020 Frame FSM, ACTIVE: the block SHALL return to IDLE when it accepts symbol FRAME_LEN-1.
REQ-021 Changes to Mode or ThreshUnit during ACTIVE SHALL have no effect until the next frame.
REQ-022 A frame started with Mode = 3 SHALL be demapped as 4-QAM and SHALL set ModeErr.
REQ-023 Bits per axis k SHALL be 1, 2 or 3 for 4-, 16- and 64-QAM respectively.
REQ-024 Decision thresholds SHALL be: k=1 {0}; k=2 {-2U, 0, 2U}; k=3 {-6U, -4U, -2U, 0, 2U, 4U, 6U}.
REQ-025 Thresholds SHALL be computed at DATA_W+4 signed bits so that no overflow occurs.
REQ-026 Axis level L SHALL equal the number of thresholds t with sample >= t, giving L in 0..2^k-1.
REQ-027 The I field SHALL equal gray(L_re), where gray(x) = x ^ (x>>1).
REQ-028 The Q field SHALL equal gray((2^k-1) - L_im).
REQ-029 OutData[2k-1:0] SHALL equal {I field, Q field}.
REQ-030 As a consequence of REQ-027 to REQ-029, 4-QAM SHALL give {Re>=0, Im<0}.
REQ-031 Pipeline stage 1 SHALL register the threshold comparisons; stage 2 SHALL encode the symbol and write the FIFO.
REQ-032 With the FIFO empty, OutValid SHALL rise 3 cycles after the accept edge.
REQ-033 The FIFO SHALL be first-word-fall-through; OutData and OutLast SHALL be held stable while OutValid=1 and OutReady=0.
REQ-034 InReady SHALL be 1 only when FIFO free slots exceed the number of occupied pipeline stages, so the FIFO never overflows.
REQ-035 A simultaneous FIFO write and read SHALL leave the occupancy unchanged and SHALL be legal at both full and empty.
REQ-036 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 OutLast SHALL travel through the pipeline and FIFO together with its symbol.

Reset
REQ-038 While Rst is asserted, the block SHALL drive OutValid=0, OutData=0, OutLast=0, ModeErr=0 and InReady=0.
REQ-039 Reset SHALL empty the FIFO, clear both pipeline stages, set the frame counter to 0 and set the FSM to IDLE.
REQ-040 InReady SHALL be 1 on the first edge after Rst deasserts.
REQ-041 Reset asserted mid-frame SHALL discard all in-flight and buffered symbols; the next accepted sample SHALL be symbol 0.

Verification
REQ-042 Mode=0, (Re,Im) = (-5,-5), (-5,5), (5,-5), (5,5), OutReady=1 -> OutData 1, 0, 3, 2, first symbol 3 cycles after its accept edge.
REQ-043 Mode=1, U=100, Re in {-300, -100, 0, 250} with Im=250 -> I field 0, 1, 3, 2; Q field 0.
REQ-044 Mode=2, U=100, Re=-700 and Re=700 -> I field 0 and 4; Re=599 -> 5; Re=600 -> 4.
REQ-045 FRAME_LEN=4, Mode changed 0->1 after symbol 1 -> symbols 0-3 demapped as 4-QAM with OutLast on symbol 3; symbol 4 demapped as 16-QAM.
REQ-046 OutReady=0 with continuous InValid -> exactly FIFO_DEPTH symbols stored and InReady=0; OutReady then 1 -> all symbols delivered in order with none lost or duplicated.
REQ-047 Mode=3 at frame start -> ModeErr=1 and symbols demapped as 4-QAM; Rst pulse mid-frame -> all outputs 0 and ModeErr cleared.

Source files
------------

// File: rtl/qam_demapper_multi.sv
// qam_demapper_multi: framed 4/16/64-QAM hard-decision demapper with a gray-coded output and a FWFT FIFO.
module qam_demapper_multi #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InRe,
    input  logic [DATA_W-1:0] InIm,
    output logic              InReady,
    input  logic [1:0]        Mode,
    input  logic [DATA_W-1:0] ThreshUnit,
    output logic              OutValid,
    output logic [5:0]        OutData,
    output logic              OutLast,
    input  logic              OutReady,
    output logic              ModeErr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = DATA_W + 4;
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic              state;
    logic [CW-1:0]     cnt, pos;
    logic [1:0]        mode_l, mode_e, k_e;
    logic [DATA_W-1:0] unit_l, unit_e;
    logic              accept, last_e;

    logic                     in_v, in_last;
    logic signed [DATA_W-1:0] in_re, in_im;
    logic [DATA_W-1:0]        in_unit;
    logic [1:0]               in_k;

    logic signed [TW-1:0] u1, re_x, im_x;
    logic signed [TW-1:0] thr [7];
    logic [6:0]           c_re, c_im;

    logic       s1_v, s1_last, s2_v, s2_last;
    logic [6:0] s1_cre, s1_cim;
    logic [1:0] s1_k;
    logic [2:0] l_re, l_im, top, g_i, g_q;
    logic [5:0] enc, s2_data;

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, free;
    logic [1:0]    occ;
    logic          wr, rd;

    function automatic logic [2:0] level(input logic [6:0] c, input logic [1:0] k);
        logic [2:0] n;
        n = '0;
        for (int j = 0; j < 7; j++)
            if (c[j] && (k == 2'd3 || j == 3 || (k == 2'd2 && j >= 2 && j <= 4)))
                n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [2:0] gray(input logic [2:0] x);
        return x ^ (x >> 1);
    endfunction

    // Mode and unit come straight from the ports on a frame's first sample, from the latch afterwards.
    always_comb begin
        accept = InValid && InReady;
        pos    = state == IDLE ? '0 : cnt;
        last_e = pos == CW'(FRAME_LEN - 1);
        mode_e = state == IDLE ? Mode : mode_l;
        unit_e = state == IDLE ? ThreshUnit : unit_l;
        k_e    = mode_e == 2'd2 ? 2'd3 : mode_e == 2'd1 ? 2'd2 : 2'd1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_l  <= '0;
            unit_l  <= '0;
            ModeErr <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                mode_l <= Mode;
                unit_l <= ThreshUnit;
                if (Mode == 2'd3) ModeErr <= 1'b1;
            end
            state <= last_e ? IDLE : ACTIVE;
            cnt   <= last_e ? '0 : pos + CW'(1);
        end
    end

    always_comb begin
        u1     = $signed({4'b0, in_unit});
        re_x   = {{4{in_re[DATA_W-1]}}, in_re};
        im_x   = {{4{in_im[DATA_W-1]}}, in_im};
        thr[3] = '0;
        thr[4] = u1 <<< 1;
        thr[5] = u1 <<< 2;
        thr[6] = thr[4] + thr[5];
        thr[2] = -thr[4];
        thr[1] = -thr[5];
        thr[0] = -thr[6];
        for (int j = 0; j < 7; j++) begin
            c_re[j] = re_x >= thr[j];
            c_im[j] = im_x >= thr[j];
        end
    end

    always_comb begin
        l_re = level(s1_cre, s1_k);
        l_im = level(s1_cim, s1_k);
        top  = (3'd1 << s1_k) - 3'd1;
        g_i  = gray(l_re);
        g_q  = gray(top - l_im);
        enc  = s1_k == 2'd3 ? {g_i, g_q} :
               s1_k == 2'd2 ? {2'b0, g_i[1:0], g_q[1:0]} : {4'b0, g_i[0], g_q[0]};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            in_v    <= 1'b0;
            in_last <= 1'b0;
            in_re   <= '0;
            in_im   <= '0;
            in_unit <= '0;
            in_k    <= 2'd1;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_cre  <= '0;
            s1_cim  <= '0;
            s1_k    <= 2'd1;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_data <= '0;
        end else begin
            in_v    <= accept;
            in_last <= last_e;
            in_re   <= InRe;
            in_im   <= InIm;
            in_unit <= unit_e;
            in_k    <= k_e;
            s1_v    <= in_v;
            s1_last <= in_last;
            s1_cre  <= c_re;
            s1_cim  <= c_im;
            s1_k    <= in_k;
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_data <= enc;
        end
    end

    // Admission reserves a FIFO slot for every symbol still in the pipeline.
    always_comb begin
        wr       = s2_v;
        rd       = OutValid && OutReady;
        OutValid = count != '0;
        {OutLast, OutData} = OutValid ? mem[rd_ptr] : 7'd0;
        free     = (AW+1)'(FIFO_DEPTH) - count;
        occ      = 2'(in_v) + 2'(s1_v) + 2'(s2_v);
        InReady  = !Rst && free > (AW+1)'(occ);
    end

    always_ff @(posedge Clk)
        if (wr) mem[wr_ptr] <= {s2_last, s2_data};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= wr && !rd ? count + (AW+1)'(1) : rd && !wr ? count - (AW+1)'(1) : count;
        end
    end
endmodule

// File: tb/tb_qam_demapper_multi.sv
// tb_qam_demapper_multi: randomized scoreboard bench against an arithmetic constellation model.
module tb_qam_demapper_multi;
    localparam int DW = 24;
    localparam int FD = 8;
    localparam int FL = 4;

    logic          Clk, Rst, InValid, InReady, OutValid, OutLast, OutReady, ModeErr;
    logic [DW-1:0] InRe, InIm, ThreshUnit;
    logic [1:0]    Mode;
    logic [5:0]    OutData;

    int         checks, errors, rmode;
    logic [6:0] q[$];
    int         m_cnt, m_mode, m_err;
    longint     m_unit;
    logic       stalled;
    logic [6:0] held;

    qam_demapper_multi #(.DATA_W(DW), .FIFO_DEPTH(FD), .FRAME_LEN(FL)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InRe(InRe), .InIm(InIm), .InReady(InReady),
        .Mode(Mode), .ThreshUnit(ThreshUnit), .OutValid(OutValid), .OutData(OutData),
        .OutLast(OutLast), .OutReady(OutReady), .ModeErr(ModeErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        OutReady = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            OutReady = rmode == 2 ? ($urandom_range(0, 3) != 0) : (rmode == 1);
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int gray(input int x);
        return x ^ (x >> 1);
    endfunction

    // Level = number of thresholds 2*j*U (|j| < 2^(k-1)) at or below the sample.
    task automatic push_exp(input int re, input int im, input int mode, input int unit);
        int k, h, lre, lim;
        logic last;
        if (m_cnt == 0) begin
            m_mode = mode;
            m_unit = longint'(unsigned'(unit));
            if (mode == 3) m_err = 1;
        end
        k = m_mode == 2 ? 3 : m_mode == 1 ? 2 : 1;
        h = (1 << (k - 1)) - 1;
        lre = 0;
        lim = 0;
        for (int j = -h; j <= h; j++) begin
            if (longint'(re) >= 2 * j * m_unit) lre++;
            if (longint'(im) >= 2 * j * m_unit) lim++;
        end
        last = m_cnt == FL - 1;
        m_cnt = (m_cnt + 1) % FL;
        q.push_back({last, 6'((gray(lre) << k) | gray((1 << k) - 1 - lim))});
    endtask

    task automatic cycle(input logic iv, input int re, input int im, input int mode, input int unit, output logic acc);
        InValid = iv;
        InRe = DW'(re);
        InIm = DW'(im);
        Mode = 2'(mode);
        ThreshUnit = DW'(unit);
        @(negedge Clk);
        acc = iv && InReady;
        if (acc) push_exp(re, im, mode, unit);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic send(input int re, input int im, input int mode, input int unit);
        logic a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 100) begin
            cycle(1'b1, re, im, mode, unit, a);
            n++;
        end
        chk("send_accepted", a, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge Clk);
            n++;
        end
        chk("drain_remaining", q.size(), 0);
        #1;
    endtask

    function automatic int rnd_sample(input int unit);
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        if (unit < (1 << 20) && $urandom_range(0, 1) == 1)
            return 2 * ($urandom_range(0, 8) - 4) * unit + $urandom_range(0, 2) - 1;
        return int'(r);
    endfunction

    function automatic int rnd_unit();
        int s;
        s = $urandom_range(0, 3);
        return s == 0 ? $urandom_range(0, 3) : s == 3 ? int'($urandom & 32'hFFFFFF) : $urandom_range(1, 1000);
    endfunction

    initial begin
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge Clk);
            if (OutValid && stalled) chk("hold_stable", {OutLast, OutData}, held);
            stalled = OutValid && !OutReady;
            held = {OutLast, OutData};
            if (OutValid && OutReady) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected got %0d expected none at %0t", {OutLast, OutData}, $time);
                end else chk("out_symbol", {OutLast, OutData}, q.pop_front());
            end
        end
    end

    initial begin
        logic a;
        int u;
        checks = 0;
        errors = 0;
        m_cnt = 0;
        m_mode = 0;
        m_unit = 0;
        m_err = 0;
        rmode = 1;
        Rst = 1'b1;
        InValid = 1'b0;
        InRe = '0;
        InIm = '0;
        Mode = '0;
        ThreshUnit = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_outdata", OutData, 0);
        chk("rst_outlast", OutLast, 0);
        chk("rst_moderr", ModeErr, 0);
        chk("rst_inready", InReady, 0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("inready_after_rst", InReady, 1);
        @(posedge Clk);
        #1;
        send(-5, -5, 0, 7);
        repeat (3) @(negedge Clk);
        chk("latency_not_early", OutValid, 0);
        @(negedge Clk);
        chk("latency_3", OutValid, 1);
        @(posedge Clk);
        #1;
        send(-5, 5, 0, 7);
        send(5, -5, 0, 7);
        send(5, 5, 0, 7);
        send(-300, 250, 1, 100);
        send(-100, 250, 1, 100);
        send(0, 250, 1, 100);
        send(250, 250, 1, 100);
        send(-700, 0, 2, 100);
        send(700, 0, 2, 100);
        send(599, 0, 2, 100);
        send(600, 0, 2, 100);
        send(3, -3, 0, 9);
        send(-3, 3, 0, 9);
        send(150, -150, 1, 100);
        send(-150, 150, 1, 100);
        send(150, -150, 1, 100);
        send(-250, 50, 1, 100);
        send(250, -50, 1, 100);
        send(50, 250, 1, 100);
        drain();
        rmode = 0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 40; i++) cycle(1'b1, rnd_sample(50), rnd_sample(50), $urandom_range(0, 2), 50, a);
        chk("fill_stored", q.size(), FD);
        chk("fill_inready", InReady, 0);
        chk("fill_outvalid", OutValid, 1);
        rmode = 1;
        drain();
        while (m_cnt != 0) send(rnd_sample(20), rnd_sample(20), 0, 20);
        chk("moderr_clear", ModeErr, m_err);
        send(4, -4, 3, 5);
        send(-4, 4, 3, 5);
        @(negedge Clk);
        chk("moderr_set", ModeErr, m_err);
        @(posedge Clk);
        #1 Rst = 1'b1;
        q.delete();
        m_cnt = 0;
        m_err = 0;
        #1;
        chk("midrst_outvalid", OutValid, 0);
        chk("midrst_outdata", OutData, 0);
        chk("midrst_outlast", OutLast, 0);
        chk("midrst_moderr", ModeErr, 0);
        chk("midrst_inready", InReady, 0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        send(-5, -5, 0, 0);
        rmode = 2;
        for (int i = 0; i < 1500; i++) begin
            u = rnd_unit();
            cycle($urandom_range(0, 3) != 0, rnd_sample(u), rnd_sample(u), $urandom_range(0, 3), u, a);
        end
        rmode = 1;
        drain();
        chk("moderr_final", ModeErr, m_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
